// File: rtl/vga_timing_param.sv
// Parameterised VGA raster timing generator; optional colour-bar source under VGA_TEST_PATTERN_EN.
// Latency: sync and colour lag pix_x/pix_y by PIPE_DLY+1 pixel ticks; pix_req and frame_start are undelayed.
// Backpressure: none, free-running; the pixel source must return rgb_in exactly PIPE_DLY ticks after pix_req.
module vga_timing_param #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter int PIPE_DLY = 2,
    parameter int COLOR_W  = 4,
    parameter bit SYNC_POL = 1'b0,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3*COLOR_W-1:0] rgb_in,
    input  logic                 pattern_sel,
    output logic [XW-1:0]        pix_x,
    output logic [YW-1:0]        pix_y,
    output logic                 pix_req,
    output logic                 frame_start,
    output logic                 vga_hs,
    output logic                 vga_vs,
    output logic [COLOR_W-1:0]   vga_red,
    output logic [COLOR_W-1:0]   vga_green,
    output logic [COLOR_W-1:0]   vga_blue
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    localparam logic [XW-1:0] H_LAST    = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT_END = XW'(H_ACTIVE);
    localparam logic [XW-1:0] H_SYN_BEG = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] H_SYN_END = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_LAST    = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT_END = YW'(V_ACTIVE);
    localparam logic [YW-1:0] V_SYN_BEG = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] V_SYN_END = YW'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_TEST_PATTERN_EN
    localparam int PW = XW + 3;
`else
    localparam int PW = 3;
`endif

    logic [DW-1:0]        div;
    logic                 tick;
    logic                 x_last;
    logic                 y_last;
    logic [PW-1:0]        raw_vec;
    logic [PW-1:0]        dly_vec;
    logic [3*COLOR_W-1:0] rgb_sel;
    logic                 hs_q;
    logic                 vs_q;
    logic [3*COLOR_W-1:0] rgb_q;

    assign tick   = (div == DIV_LAST);
    assign x_last = (pix_x == H_LAST);
    assign y_last = (pix_y == V_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div   <= '0;
            pix_x <= '0;
            pix_y <= '0;
        end else begin
            div <= tick ? '0 : div + DW'(1);
            if (tick) begin
                pix_x <= x_last ? '0 : pix_x + XW'(1);
                if (x_last)
                    pix_y <= y_last ? '0 : pix_y + YW'(1);
            end
        end
    end

    assign pix_req     = (pix_x < H_ACT_END) && (pix_y < V_ACT_END);
    assign frame_start = tick && x_last && y_last;

    // Bit order of the delay line: {[pix_x,] active, vsync, hsync}
`ifdef VGA_TEST_PATTERN_EN
    assign raw_vec = {pix_x, pix_req,
                      (pix_y >= V_SYN_BEG) && (pix_y < V_SYN_END),
                      (pix_x >= H_SYN_BEG) && (pix_x < H_SYN_END)};
`else
    assign raw_vec = {pix_req,
                      (pix_y >= V_SYN_BEG) && (pix_y < V_SYN_END),
                      (pix_x >= H_SYN_BEG) && (pix_x < H_SYN_END)};
`endif

    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign dly_vec = raw_vec;
        end else begin : g_dly
            logic [PW-1:0] sr [PIPE_DLY];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_DLY; i++)
                        sr[i] <= '0;
                end else if (tick) begin
                    sr[0] <= raw_vec;
                    for (int i = 1; i < PIPE_DLY; i++)
                        sr[i] <= sr[i-1];
                end
            end
            assign dly_vec = sr[PIPE_DLY-1];
        end
    endgenerate

`ifdef VGA_TEST_PATTERN_EN
    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    logic [2:0]           bar;
    logic [3*COLOR_W-1:0] pat_rgb;
    assign bar     = 3'(dly_vec[PW-1:3] / XW'(BAR_W));
    assign pat_rgb = {{COLOR_W{~bar[1]}}, {COLOR_W{~bar[2]}}, {COLOR_W{~bar[0]}}};
    assign rgb_sel = pattern_sel ? pat_rgb : rgb_in;
`else
    logic unused_pattern_sel;
    assign unused_pattern_sel = pattern_sel;
    assign rgb_sel            = rgb_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            rgb_q <= '0;
        end else if (tick) begin
            hs_q  <= dly_vec[0];
            vs_q  <= dly_vec[1];
            rgb_q <= dly_vec[2] ? rgb_sel : '0;
        end
    end

    assign vga_hs    = hs_q ? SYNC_POL : ~SYNC_POL;
    assign vga_vs    = vs_q ? SYNC_POL : ~SYNC_POL;
    assign vga_red   = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign vga_green = rgb_q[2*COLOR_W-1:COLOR_W];
    assign vga_blue  = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_param.sv
// Bench for vga_timing_param: two small-raster instances (CLK_DIV=4/PIPE_DLY=2/SYNC_POL=0 and
// CLK_DIV=1/PIPE_DLY=0/SYNC_POL=1) checked every cycle against an elapsed-time raster model.
module tb_vga_timing_param;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic [4:0]  x;
        logic [3:0]  y;
        logic        req;
        logic        fs;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pattern_sel;
    logic [11:0] rgb_a, rgb_b;
    logic [4:0]  px_a, px_b;
    logic [3:0]  py_a, py_b;
    logic        req_a, req_b, fs_a, fs_b, hs_a, hs_b, vs_a, vs_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;

    int checks = 0;
    int errors = 0;
    int n = 0;
    int phase = 0;
    int hs_lo = 0, vs_lo = 0;
    int last_a = -1, last_b = -1;

    always #5 clk = ~clk;

    vga_timing_param #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(4), .PIPE_DLY(2), .COLOR_W(4), .SYNC_POL(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .rgb_in(rgb_a), .pattern_sel(pattern_sel),
        .pix_x(px_a), .pix_y(py_a), .pix_req(req_a), .frame_start(fs_a),
        .vga_hs(hs_a), .vga_vs(vs_a), .vga_red(r_a), .vga_green(g_a), .vga_blue(b_a)
    );

    vga_timing_param #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(1), .PIPE_DLY(0), .COLOR_W(4), .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .rgb_in(rgb_b), .pattern_sel(pattern_sel),
        .pix_x(px_b), .pix_y(py_b), .pix_req(req_b), .frame_start(fs_b),
        .vga_hs(hs_b), .vga_vs(vs_b), .vga_red(r_b), .vga_green(g_b), .vga_blue(b_b)
    );

    // Clock edges since reset release; held at 0 while reset is high.
    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    function automatic int wrap(input int c);
        return ((c % FRAME) + FRAME) % FRAME;
    endfunction

    // Pixel source content for raster index c: {x, y, ~x}.
    function automatic logic [11:0] color_of(input int c);
        logic [3:0] xx, yy;
        xx = 4'(c % HT);
        yy = 4'(c / HT);
        return {xx, yy, ~xx};
    endfunction

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                         12'hF0F, 12'hF00, 12'h00F, 12'h000};
`endif

    function automatic obs_t model(input int cnt, input int cd, input int pd, input bit pol, input bit psel);
        obs_t o;
        int t, c, co, xo, yo;
        t = cnt / cd;
        c = t % FRAME;
        o.x   = 5'(c % HT);
        o.y   = 4'(c / HT);
        o.req = ((c % HT) < HA) && ((c / HT) < VA);
        o.fs  = (cnt % cd == cd - 1) && (c == FRAME - 1);
        o.hs  = ~pol;
        o.vs  = ~pol;
        o.rgb = '0;
        if (t >= pd + 1) begin
            co = (t - pd - 1) % FRAME;
            xo = co % HT;
            yo = co / HT;
            if (xo >= HA + HF && xo < HA + HF + HS) o.hs = pol;
            if (yo >= VA + VF && yo < VA + VF + VS) o.vs = pol;
            if (xo < HA && yo < VA) begin
                o.rgb = color_of(co);
`ifdef VGA_TEST_PATTERN_EN
                if (psel) o.rgb = BARS[xo / (HA / 8)];
`endif
            end
        end
`ifndef VGA_TEST_PATTERN_EN
        if (psel) o.rgb = o.rgb;
`endif
        return o;
    endfunction

    task automatic cmp(input string tag, input obs_t e, input obs_t a);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s n=%0d got x=%0d y=%0d req=%b fs=%b hs=%b vs=%b rgb=%h expected x=%0d y=%0d req=%b fs=%b hs=%b vs=%b rgb=%h",
                     tag, n, a.x, a.y, a.req, a.fs, a.hs, a.vs, a.rgb, e.x, e.y, e.req, e.fs, e.hs, e.vs, e.rgb);
        end
    endtask

    task automatic lit(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s n=%0d got %0d expected %0d", tag, n, act, exp);
        end
    endtask

    // Source: rgb_in returned PIPE_DLY ticks after the request for the same pixel.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            #1;
            rgb_a = color_of(wrap(n / 4 - 2));
            rgb_b = color_of(wrap(n));
        end
    end

    always @(negedge clk) begin
        cmp("dut_a_model", model(n, 4, 2, 1'b0, pattern_sel),
            {px_a, py_a, req_a, fs_a, hs_a, vs_a, r_a, g_a, b_a});
        cmp("dut_b_model", model(n, 1, 0, 1'b1, pattern_sel),
            {px_b, py_b, req_b, fs_b, hs_b, vs_b, r_b, g_b, b_b});
    end

    task automatic points();
        if (phase == 1 && n >= 960 && n < 1920) begin
            if (hs_a == 1'b0) hs_lo++;
            if (vs_a == 1'b0) vs_lo++;
        end
        if (fs_a) begin
            if (last_a >= 0) lit("a_fs_period", n - last_a, 960);
            last_a = n;
        end
        if (fs_b) begin
            if (last_b >= 0) lit("b_fs_period", n - last_b, 240);
            last_b = n;
        end
        case (n)
            3:   lit("a_x_before_4th_edge", int'(px_a), 0);
            4:   lit("a_x_after_4th_edge", int'(px_a), 1);
            5:   lit("b_rgb_lag_1clk", int'({r_b, g_b, b_b}), 'h40B);
            18:  lit("b_hs_before_sync", int'(hs_b), 0);
            19:  lit("b_hs_in_sync", int'(hs_b), 1);
            24:  lit("b_line_800_scaled", int'({py_b, px_b}), 'h20);
            33:  lit("a_rgb_at_x5", int'({r_a, g_a, b_a}), 'h50A);
            77:  lit("a_rgb_blank", int'({r_a, g_a, b_a}), 0);
            83:  lit("a_hs_before_sync", int'(hs_a), 1);
            85:  lit("a_hs_in_sync", int'(hs_a), 0);
            958: lit("a_fs_pre", int'(fs_a), 0);
            959: lit("a_fs_pulse", int'(fs_a), 1);
            960: lit("a_fs_post_and_origin", int'({fs_a, py_a, px_a}), 0);
            default: ;
        endcase
    endtask

    initial begin
        rst = 1'b1;
        pattern_sel = 1'b0;
        rgb_a = '0;
        rgb_b = '0;
        repeat (3) @(negedge clk);
        lit("rst_a_pos", int'({py_a, px_a}), 0);
        lit("rst_a_sync", int'({hs_a, vs_a}), 3);
        lit("rst_b_sync", int'({hs_b, vs_b}), 0);
        lit("rst_colour_fs", int'({r_a, g_a, b_a, r_b, g_b, b_b, fs_a, fs_b}), 0);
        rst = 1'b0;
        phase = 1;
        for (int i = 0; i < 2400 && n < 2330; i++) begin
            @(negedge clk);
            points();
        end
        lit("a_hs_low_clks_per_frame", hs_lo, 120);
        lit("a_vs_low_clks_per_frame", vs_lo, 192);
        lit("a_midframe_y", int'(py_a), 4);

        phase = 2;
        #2 rst = 1'b1;
        #1;
        lit("midrst_a_pos", int'({py_a, px_a}), 0);
        lit("midrst_a_sync", int'({hs_a, vs_a}), 3);
        lit("midrst_b_sync", int'({hs_b, vs_b}), 0);
        lit("midrst_colour", int'({r_a, g_a, b_a, r_b, g_b, b_b}), 0);
        pattern_sel = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_a = -1;
        last_b = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            points();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
